// File: rtl/ex_operand_stage.sv
// ex_operand_stage: execute-stage operand forwarding/select with a one-deep valid/ready output register.
// Optional hazard stall counter enabled by defining EX_OPERAND_STALL_CNT_EN.
module ex_operand_stage #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  input  logic [XLEN-1:0]           rs1_data,
  input  logic [XLEN-1:0]           rs2_data,
  input  logic [XLEN-1:0]           pc,
  input  logic [XLEN-1:0]           imm,
  input  logic                      aluinputpc,
  input  logic                      alusrc,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic                      hazard_stall,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           alu_op1,
  output logic [XLEN-1:0]           alu_op2,
  output logic [XLEN-1:0]           store_data,
  output logic [31:0]               stall_cycles
);
  logic [XLEN:0] rs1_res, rs2_res;
  logic accept, out_valid_d, out_valid_q;
  logic [XLEN-1:0] alu_op1_d, alu_op1_q, alu_op2_d, alu_op2_q, store_data_d, store_data_q;
  // Returns {pending, value}; scanning oldest to youngest lets the youngest match win.
  function automatic logic [XLEN:0] resolve(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] rf);
    logic [XLEN:0] r;
    r = {1'b0, rf};
    for (int i = NUM_FWD - 1; i >= 0; i--)
      if (fwd_valid[i] && fwd_addr[i*ADDR_W +: ADDR_W] == a)
        r = {fwd_pending[i], fwd_data[i*XLEN +: XLEN]};
    return (a == '0) ? '0 : r;
  endfunction
  always_comb begin
    rs1_res      = resolve(rs1_addr, rs1_data);
    rs2_res      = resolve(rs2_addr, rs2_data);
    hazard_stall = in_valid & (rs1_res[XLEN] | rs2_res[XLEN]);
    in_ready     = ~out_valid_q | out_ready;
    accept       = in_valid & in_ready & ~hazard_stall & ~flush;
    out_valid_d  = flush ? 1'b0 : accept ? 1'b1 : (out_valid_q & out_ready) ? 1'b0 : out_valid_q;
    alu_op1_d    = accept ? (aluinputpc ? pc : rs1_res[XLEN-1:0]) : alu_op1_q;
    alu_op2_d    = accept ? (alusrc ? imm : rs2_res[XLEN-1:0]) : alu_op2_q;
    store_data_d = accept ? rs2_res[XLEN-1:0] : store_data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      store_data_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      store_data_q <= store_data_d;
    end
  end
  assign out_valid  = out_valid_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign store_data = store_data_q;
`ifdef EX_OPERAND_STALL_CNT_EN
  logic [31:0] stall_cycles_d, stall_cycles_q;
  always_comb stall_cycles_d = (hazard_stall && ~&stall_cycles_q) ? stall_cycles_q + 32'd1 : stall_cycles_q;
  always_ff @(posedge clk) begin
    if (!rst) stall_cycles_q <= '0;
    else stall_cycles_q <= stall_cycles_d;
  end
  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed self-checking bench for ex_operand_stage (NUM_FWD=3).
module tb_ex_operand_stage;
  localparam int XLEN = 32, ADDR_W = 5, NUM_FWD = 3;
`ifdef EX_OPERAND_STALL_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif
  logic clk = 1'b0, rst, flush, in_valid, in_ready, aluinputpc, alusrc;
  logic [ADDR_W-1:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data, pc, imm, alu_op1, alu_op2, store_data;
  logic [NUM_FWD-1:0] fwd_valid, fwd_pending;
  logic [NUM_FWD*ADDR_W-1:0] fwd_addr;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic hazard_stall, out_valid, out_ready;
  logic [31:0] stall_cycles;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ex_operand_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc(pc), .imm(imm), .aluinputpc(aluinputpc), .alusrc(alusrc),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .hazard_stall(hazard_stall), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .store_data(store_data), .stall_cycles(stall_cycles)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_fwd(input int i, input logic v, input logic p, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    fwd_valid[i] = v;
    fwd_pending[i] = p;
    fwd_addr[i*ADDR_W +: ADDR_W] = a;
    fwd_data[i*XLEN +: XLEN] = d;
  endtask
  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; aluinputpc = 1'b0; alusrc = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0; pc = '0; imm = '0;
    fwd_valid = '0; fwd_pending = '0; fwd_addr = '0; fwd_data = '0; out_ready = 1'b0;
    step(); step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_op1", alu_op1, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_stall_cnt", stall_cycles, 32'd0);
    rst = 1'b1;
    // youngest of two matching producers wins
    in_valid = 1'b1; out_ready = 1'b1; rs1_addr = 5'd5; rs1_data = 32'h5555;
    set_fwd(0, 1'b1, 1'b0, 5'd5, 32'h11);
    set_fwd(2, 1'b1, 1'b0, 5'd5, 32'h33);
    #1 check("fwd_no_hazard", {31'b0, hazard_stall}, 32'd0);
    step();
    check("fwd_valid_out", {31'b0, out_valid}, 32'd1);
    check("fwd_youngest", alu_op1, 32'h11);
    check("fwd_rs2_zero", alu_op2, 32'd0);
    set_fwd(0, 1'b0, 1'b0, 5'd5, 32'h11);
    step();
    check("fwd_oldest", alu_op1, 32'h33);
    check("b2b_valid", {31'b0, out_valid}, 32'd1);
    set_fwd(2, 1'b0, 1'b0, 5'd5, 32'h33);
    step();
    check("rf_fallback", alu_op1, 32'h5555);
    // pending youngest producer shadows a ready older one
    rs1_addr = 5'd0; rs2_addr = 5'd7; rs2_data = 32'h7777;
    set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h1);
    set_fwd(1, 1'b1, 1'b0, 5'd7, 32'h99);
    #1 check("hz_stall", {31'b0, hazard_stall}, 32'd1);
    check("hz_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("hz_no_accept", {31'b0, out_valid}, 32'd0);
    step(); step(); step();
    check("hz_still", {31'b0, hazard_stall}, 32'd1);
    check("hz_stall_cnt", stall_cycles, CNT_ON ? 32'd4 : 32'd0);
    set_fwd(0, 1'b1, 1'b0, 5'd7, 32'hAB);
    #1 check("hz_cleared", {31'b0, hazard_stall}, 32'd0);
    step();
    check("hz_op2", alu_op2, 32'hAB);
    check("hz_store", store_data, 32'hAB);
    check("hz_op1_x0", alu_op1, 32'd0);
    // x0 never forwards and is never pending
    fwd_valid = '0; fwd_pending = '0;
    rs2_addr = 5'd0;
    set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1 check("x0_no_hazard", {31'b0, hazard_stall}, 32'd0);
    step();
    check("x0_op1", alu_op1, 32'd0);
    check("x0_stall_cnt", stall_cycles, CNT_ON ? 32'd4 : 32'd0);
    aluinputpc = 1'b1; pc = 32'h100;
    step();
    check("pc_op1", alu_op1, 32'h100);
    alusrc = 1'b1; imm = 32'h44;
    step();
    check("imm_op2", alu_op2, 32'h44);
    check("imm_store", store_data, 32'd0);
    // back-pressure freezes captured values
    aluinputpc = 1'b0; alusrc = 1'b0; fwd_valid = '0; fwd_pending = '0;
    rs1_addr = 5'd3; rs1_data = 32'h1234;
    step();
    out_ready = 1'b0;
    step();
    check("bp_capture", alu_op1, 32'h1234);
    set_fwd(0, 1'b1, 1'b0, 5'd3, 32'hDEAD);
    rs1_data = 32'h4321;
    #1 check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    step(); step();
    check("bp_frozen", alu_op1, 32'h1234);
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1 check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("bp_reload_valid", {31'b0, out_valid}, 32'd1);
    check("bp_reload", alu_op1, 32'hDEAD);
    // flush beats accept and consume
    flush = 1'b1;
    set_fwd(0, 1'b1, 1'b0, 5'd3, 32'hBEEF);
    step();
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_held", alu_op1, 32'hDEAD);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    flush = 1'b0;
    step();
    check("post_flush", alu_op1, 32'hBEEF);
    rst = 1'b0;
    step();
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_op1", alu_op1, 32'd0);
    check("mid_rst_store", store_data, 32'd0);
    check("mid_rst_cnt", stall_cycles, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
